// File: rtl/regfile_multiport.sv
// Multiport register file: NUM_RD synchronous read ports, one write port, optional zero register, power-up clear engine.
// Latency: 1 cycle from read request to rd_data/rd_valid. Backpressure: none; ready stays low for DEPTH+1 cycles after reset.
// Define REGFILE_BYPASS_EN for write-first same-edge collisions; the default build is read-first.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       ready,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [ADDR_W-1:0]   clr_ptr_nxt;
    logic                clr_we;
    logic                wr_acc;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   rd_a   [NUM_RD];
    logic [DATA_W-1:0]   rd_val [NUM_RD];

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        clr_we      = 1'b0;
        if (state == CLEAR) begin
            clr_we      = 1'b1;
            clr_ptr_nxt = clr_ptr + 1'b1;
            if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                state_nxt = RUN;
            end
        end
    end

    // ready lags the state by one edge, so nothing is accepted on the edge that finishes the clear
    always_ff @(posedge clock) begin
        if (reset) begin
            ready <= 1'b0;
        end else begin
            ready <= (state == RUN);
        end
    end

    assign wr_acc = ready && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (clr_we) begin
                mem[clr_ptr] <= '0;
            end else if (wr_acc) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_a[p]   = rd_addr[p*ADDR_W +: ADDR_W];
            rd_val[p] = mem[rd_a[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (wr_addr == rd_a[p])) begin
                rd_val[p] = wr_data;
            end
`endif
            // zero-register masking wins over any bypass
            if ((ZERO_REG != 0) && (rd_a[p] == '0)) begin
                rd_val[p] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !ready) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_valid[p] <= rd_en[p];
                if (rd_en[p]) begin
                    rd_data[p*DATA_W +: DATA_W] <= rd_val[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_regfile_multiport;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      ready;
    logic [NUM_RD-1:0]         rd_en;
    logic [NUM_RD*ADDR_W-1:0]  rd_addr;
    logic [NUM_RD*DATA_W-1:0]  rd_data;
    logic [NUM_RD-1:0]         rd_valid;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;

    always #5 clock = ~clock;

    regfile_multiport #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
    ) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: readiness is a count of non-reset edges since reset;
    // contents are all zero once a reset is seen, since nothing is exposed before then.
    bit                 model_valid = 1'b0;
    int                 cnt;
    logic               exp_ready;
    logic [NUM_RD-1:0]  exp_valid;
    logic [DATA_W-1:0]  exp_data [NUM_RD];
    logic [DATA_W-1:0]  mem_m    [DEPTH];

    always @(posedge clock) begin : model
        logic [ADDR_W-1:0] a;
        if (reset) begin
            model_valid = 1'b1;
            cnt         = 0;
            exp_ready   = 1'b0;
            exp_valid   = '0;
            for (int p = 0; p < NUM_RD; p++) exp_data[p] = '0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end else if (model_valid) begin
            if (exp_ready) begin
                for (int p = 0; p < NUM_RD; p++) begin
                    a = rd_addr[p*ADDR_W +: ADDR_W];
                    exp_valid[p] = rd_en[p];
                    if (rd_en[p]) begin
                        if (a == 0)                              exp_data[p] = '0;
                        else if (BYP && wr_en && wr_addr == a)   exp_data[p] = wr_data;
                        else                                     exp_data[p] = mem_m[a];
                    end
                end
                if (wr_en && wr_addr != 0) mem_m[wr_addr] = wr_data;
            end else begin
                exp_valid = '0;
                for (int p = 0; p < NUM_RD; p++) exp_data[p] = '0;
            end
            if (cnt < DEPTH + 1) cnt++;
            exp_ready = (cnt >= DEPTH + 1);
        end
    end

    always @(negedge clock) begin : compare
        if (model_valid) begin
            check("ready", {63'd0, ready}, {63'd0, exp_ready});
            check("rd_valid", {62'd0, rd_valid}, {62'd0, exp_valid});
            for (int p = 0; p < NUM_RD; p++) begin
                check("rd_data", {32'd0, rd_data[p*DATA_W +: DATA_W]}, {32'd0, exp_data[p]});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset   = 1'b1;
        rd_en   = '0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        tick();
        reset = 1'b0;
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_valid", {62'd0, rd_valid}, 64'd0);
        check("rst_data", rd_data, 64'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            check("clear_ready", {63'd0, ready}, 64'd0);
        end
        tick();
        check("ready_up", {63'd0, ready}, 64'd1);

        for (int a = 0; a < DEPTH; a++) begin
            rd_en   = 2'b11;
            rd_addr = {ADDR_W'(a), ADDR_W'(a)};
            tick();
            check("init_valid", {62'd0, rd_valid}, 64'd3);
            check("init_data", rd_data, 64'd0);
        end

        rd_en = 2'b00; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        check("r5_no_early_valid", {62'd0, rd_valid}, 64'd0);
        wr_en = 1'b0; rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
        tick();
        check("r5_valid", {62'd0, rd_valid}, 64'd3);
        check("r5_data", rd_data, 64'hDEADBEEF_DEADBEEF);

        rd_en = 2'b00; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        tick();
        wr_en = 1'b0; rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
        tick();
        check("r0_zero", {32'd0, rd_data[31:0]}, 64'd0);

        rd_en = 2'b00; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
        tick();
        wr_data = 32'h2; rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
        tick();
        check("collide_r7", {32'd0, rd_data[31:0]}, BYP ? 64'd2 : 64'd1);
        wr_en = 1'b0;
        tick();
        check("after_r7", {32'd0, rd_data[31:0]}, 64'd2);

        rd_en = 2'b00; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
        tick();
        reset = 1'b1; wr_data = 32'hFFFFFFFF;
        tick();
        reset = 1'b0; rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
        for (int i = 1; i <= DEPTH + 1; i++) begin
            wr_data = $urandom;
            tick();
            check("clr_valid", {62'd0, rd_valid}, 64'd0);
            check("clr_ready", {63'd0, ready}, (i == DEPTH + 1) ? 64'd1 : 64'd0);
        end
        wr_en = 1'b0;
        tick();
        check("r9_valid", {62'd0, rd_valid}, 64'd3);
        check("r9_cleared", rd_data, 64'd0);

        rd_en = 2'b00; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
        tick();
        wr_en = 1'b0; rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
        tick();
        for (int i = 0; i < 4; i++) begin
            rd_en   = 2'b01;
            rd_addr = {(i % 2 == 0) ? 5'd4 : 5'd3, 5'd3};
            tick();
            check("hold_valid", {62'd0, rd_valid}, 64'd1);
            check("hold_port1", {32'd0, rd_data[63:32]}, 64'hA5A5A5A5);
        end

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            rd_en = NUM_RD'($urandom);
            for (int p = 0; p < NUM_RD; p++) begin
                rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
            end
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = ADDR_W'($urandom_range(0, 7));
            wr_data = $urandom;
            tick();
        end

        reset = 1'b0; rd_en = '0; wr_en = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the processor's two-read/one-write register file. It provides NUM_RD synchronous read ports and one write port, all on the rising edge. A hardwired zero register and write-to-read bypass are included. After reset, a sequential clear engine zeroes the array and holds the block not-ready until clearing completes. It sits between decode (read addresses) and writeback (write port) in the pipeline.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are discarded

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ready  out  1  high once the clear sequence is done; low during reset and clear
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  flattened; port p at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  flattened; port p at bits [p*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  per-port; high one cycle after an accepted rd_en
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address (caller resolves rd/rt destination select)
- wr_data  in  DATA_W  write data

## Operation
- FSM states are CLEAR and RUN. Reset forces CLEAR with clr_ptr=0.
- In CLEAR with reset low, each cycle writes 0 to mem[clr_ptr] and increments clr_ptr.
- When clr_ptr==DEPTH-1 is written, the FSM goes to RUN. ready is a registered copy of (state==RUN).
- In CLEAR (and while reset is high):
  - wr_en is ignored.
  - rd_en is ignored: rd_valid=0, rd_data=0.
- In RUN, a write with wr_en=1 updates mem[wr_addr] at the edge. The write is discarded if ZERO_REG=1 and wr_addr==0.
- In RUN, a read with rd_en[p]=1 registers mem[rd_addr_p] into rd_data_p and sets rd_valid[p]=1 at the next edge.
- With rd_en[p]=0, rd_valid[p]=0 and rd_data_p holds its last value.
- Read data for address 0 is forced to 0 when ZERO_REG=1, regardless of bypass.
- Ports are independent. Any number of ports may read the same address in the same cycle and must return identical data.
- If reset asserts mid-operation, the clear restarts from entry 0. Partially cleared contents are never exposed, because reads are blocked until ready.

## Timing
- Reset values: ready=0, rd_valid=0 (all ports), rd_data=0 (all ports), state=CLEAR, clr_ptr=0.
- Clear duration: reset sampled high at edge E0, then low at E1..E(DEPTH). Entries 0..DEPTH-1 are cleared at E1..E(DEPTH).
- The state is RUN after E(DEPTH). ready=1 after E(DEPTH+1). Requests are accepted from the cycle in which ready=1.
- Read latency is 1 cycle: request sampled at edge N, data and valid presented after edge N.
- Write takes effect at the sampling edge, so a read of the same address at a later edge returns the new data.
- Same-edge write and read of the same address: see Configuration.
- There is no back-pressure. The block accepts a request every cycle when ready=1.

## Configuration
- REGFILE_BYPASS_EN defined: if wr_en=1 and rd_en[p]=1 at the same edge with wr_addr==rd_addr_p, rd_data_p returns wr_data (write-first). ZERO_REG masking still applies.
- REGFILE_BYPASS_EN undefined: the same collision returns the pre-write contents (read-first). The new value is visible from the following edge.

## Test plan
(DATA_W=32, ADDR_W=5, NUM_RD=2)
- Reset for 1 cycle, then idle -> ready=0 for 33 cycles and 1 from the next cycle. Read of every address returns 0x00000000 with rd_valid=1.
- Write 0xDEADBEEF to r5, next cycle read r5 on both ports -> both ports return 0xDEADBEEF, rd_valid=2'b11, one cycle after the request.
- Write 0x12345678 to r0, then read r0 -> 0x00000000 (ZERO_REG=1).
- r7=0x1, then in the same cycle write r7=0x2 and read r7 on port 0 -> 0x2 with REGFILE_BYPASS_EN, 0x1 without. The next read returns 0x2 in both builds.
- Reset asserted for 1 cycle while r9=0xCAFEF00D, with writes attempted during CLEAR -> writes dropped and rd_valid=0 until ready. After ready, r9 reads 0x00000000.
- rd_en=2'b01 with rd_addr port 1 toggling -> rd_valid=2'b01 and rd_data port 1 holds its previous value.
